// File: rtl/cpu_mem_bridge.sv
// CPU-to-memory bridge: posts stores into a small write buffer that drains to
// the bus in the background, and performs blocking loads only after every
// older buffered store has been issued.
module cpu_mem_bridge #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cpu_memrd,
  input  logic                            cpu_memwr,
  input  logic [ADDR_W-1:0]               cpu_addr,
  input  logic [DATA_W-1:0]               cpu_wdata,
  output logic [DATA_W-1:0]               cpu_rdata,
  output logic                            cpu_stall,
  output logic                            bus_req_valid,
  input  logic                            bus_req_ready,
  output logic                            bus_req_we,
  output logic [ADDR_W-1:0]               bus_req_addr,
  output logic [DATA_W-1:0]               bus_req_wdata,
  input  logic                            bus_rsp_valid,
  input  logic [DATA_W-1:0]               bus_rsp_data,
  output logic [$clog2(WB_DEPTH+1)-1:0]   wb_count
);

  localparam int unsigned PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CW = $clog2(WB_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StRdReq,
    StRdWait,
    StRdDone
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [ADDR_W-1:0]  buf_addr_q [WB_DEPTH];
  logic [DATA_W-1:0]  buf_data_q [WB_DEPTH];

  logic push, pop, capture;
  logic full, nonempty, drain_phase;

  assign full        = (count_q == CW'(WB_DEPTH));
  assign nonempty    = (count_q != '0);
  // Buffered stores may only go out while no read owns the bus.
  assign drain_phase = (state_q == StIdle) || (state_q == StDrain) || (state_q == StRdDone);

  // Next-state, handshake and bus-request decode.
  always_comb begin
    state_d       = state_q;
    cpu_stall     = 1'b0;
    bus_req_valid = 1'b0;
    bus_req_we    = 1'b0;
    bus_req_addr  = buf_addr_q[rd_ptr_q];
    bus_req_wdata = buf_data_q[rd_ptr_q];
    push          = 1'b0;
    pop           = 1'b0;
    capture       = 1'b0;

    case (state_q)
      StIdle: begin
        // A load wins over a simultaneous store; the store is dropped.
        if (cpu_memrd) begin
          cpu_stall = 1'b1;
          state_d   = nonempty ? StDrain : StRdReq;
        end else if (cpu_memwr) begin
          // Fullness uses the registered count, so a same-cycle pop never frees a slot.
          if (full) cpu_stall = 1'b1;
          else      push      = 1'b1;
        end
      end
      StDrain: begin
        cpu_stall = 1'b1;
        if (!nonempty) state_d = StRdReq;
      end
      StRdReq: begin
        cpu_stall     = 1'b1;
        bus_req_valid = 1'b1;
        bus_req_we    = 1'b0;
        bus_req_addr  = cpu_addr;
        bus_req_wdata = '0;
        if (bus_req_ready) state_d = StRdWait;
      end
      StRdWait: begin
        cpu_stall = 1'b1;
        if (bus_rsp_valid) begin
          capture = 1'b1;
          state_d = StRdDone;
        end
      end
      StRdDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (drain_phase && nonempty) begin
      bus_req_valid = 1'b1;
      bus_req_we    = 1'b1;
      pop           = bus_req_ready;
    end

    // Reset cycle: quiet bus, no stall, no buffer or capture activity.
    if (reset) begin
      state_d       = StIdle;
      cpu_stall     = 1'b0;
      bus_req_valid = 1'b0;
      bus_req_we    = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;
      capture       = 1'b0;
    end
  end

  // FSM, buffer pointers, occupancy and load-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (capture) rdata_q <= bus_rsp_data;
    end
  end

  // Write-buffer storage; contents are meaningless until counted in.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= cpu_addr;
      buf_data_q[wr_ptr_q] <= cpu_wdata;
    end
  end

  assign cpu_rdata = rdata_q;
  assign wb_count  = count_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: directed scenarios followed by a
// randomized store/load mix checked against an in-order transaction model.
module tb_cpu_mem_bridge;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          cpu_memrd, cpu_memwr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          bus_req_valid, bus_req_ready, bus_req_we;
  logic [AW-1:0] bus_req_addr;
  logic [DW-1:0] bus_req_wdata;
  logic          bus_rsp_valid;
  logic [DW-1:0] bus_rsp_data;
  logic [CW-1:0] wb_count;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  // Model: every accepted store, in program order, must appear on the bus in order.
  logic [63:0] exp_wr[$];
  logic [63:0] wr_log[$];
  bit          rd_pending = 0;
  int          wr_during_rd = 0;

  cpu_mem_bridge #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .WB_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_memrd    (cpu_memrd),
    .cpu_memwr    (cpu_memwr),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_req_we   (bus_req_we),
    .bus_req_addr (bus_req_addr),
    .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_data (bus_rsp_data),
    .wb_count     (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus write monitor: records accepted writes, flags any write while a read is open.
  always @(negedge clk) begin
    if (!reset && bus_req_valid && bus_req_ready && bus_req_we) begin
      wr_log.push_back({bus_req_addr, bus_req_wdata});
      if (rd_pending) wr_during_rd++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_cnt"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) chk(tag, wr_log[i], exp_wr[i]);
    wr_log.delete();
    exp_wr.delete();
  endtask

  task automatic drain_all();
    cpu_memrd     = 1'b0;
    cpu_memwr     = 1'b0;
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b0;
    #1;
    for (int c = 0; c < 50 && wb_count != '0; c++) tick();
    chk("drain_empty", 64'(wb_count), 64'd0);
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rnd);
    bit done = 0;
    int mc;
    cpu_memrd = 1'b0;
    cpu_memwr = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    for (int c = 0; c < 200 && !done; c++) begin
      bus_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_rsp_valid = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      bus_rsp_data  = $urandom;
      #1;
      mc = exp_wr.size() - wr_log.size();
      chk("st_count", 64'(wb_count), 64'(mc));
      chk("st_stall", 64'(cpu_stall), 64'(mc == DEPTH));
      if (!cpu_stall) begin
        exp_wr.push_back({a, d});
        done = 1;
      end
      tick();
    end
    chk("st_accepted", 64'(done), 64'd1);
    cpu_memwr = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input bit rnd);
    bit hs = 0, sent = 0, done = 0;
    int dly = 0;
    logic [DW-1:0] exp_d = '0;
    cpu_memrd = 1'b1;
    cpu_addr  = a;
    for (int c = 0; c < 200 && !done; c++) begin
      bus_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hs && !sent) begin
        if (dly == 0) begin
          exp_d         = $urandom;
          bus_rsp_valid = 1'b1;
          bus_rsp_data  = exp_d;
          sent          = 1;
        end else begin
          bus_rsp_valid = 1'b0;
          dly--;
        end
      end else if (!hs && rnd) begin
        // Stray responses before the read is accepted must be ignored.
        bus_rsp_valid = ($urandom_range(0, 3) == 0);
        bus_rsp_data  = $urandom;
      end else begin
        bus_rsp_valid = 1'b0;
      end
      #1;
      if (!cpu_stall) begin
        done = 1;
        chk("ld_data", 64'(cpu_rdata), 64'(exp_d));
      end else if (!hs && bus_req_valid && !bus_req_we && bus_req_ready) begin
        hs         = 1;
        rd_pending = 1;
        dly        = rnd ? int'($urandom_range(0, 2)) : 0;
        chk("ld_addr", 64'(bus_req_addr), 64'(a));
        chk("ld_order", 64'(wr_log.size()), 64'(exp_wr.size()));
      end
      tick();
    end
    chk("ld_done", 64'({hs, sent, done}), 64'b111);
    rd_pending    = 0;
    cpu_memrd     = 1'b0;
    cpu_memwr     = 1'b0;
    bus_rsp_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;

    // Reset: stall must stay low even with requests present.
    reset         = 1'b1;
    cpu_memrd     = 1'b1;
    cpu_memwr     = 1'b1;
    cpu_addr      = '0;
    cpu_wdata     = '0;
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = '0;
    tick();
    tick();
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_valid", 64'(bus_req_valid), 64'd0);
    cpu_memrd = 1'b0;
    cpu_memwr = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(wb_count), 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_idle_valid", 64'(bus_req_valid), 64'd0);
    tick();

    // Single posted store with ready high.
    cpu_memwr = 1'b1;
    cpu_addr  = 32'h10;
    cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("st1_stall", 64'(cpu_stall), 64'd0);
    exp_wr.push_back({32'h10, 32'hDEADBEEF});
    tick();
    cpu_memwr = 1'b0;
    #1;
    chk("st1_valid", 64'(bus_req_valid), 64'd1);
    chk("st1_we", 64'(bus_req_we), 64'd1);
    chk("st1_addr", 64'(bus_req_addr), 64'h10);
    chk("st1_data", 64'(bus_req_wdata), 64'hDEADBEEF);
    chk("st1_cnt1", 64'(wb_count), 64'd1);
    tick();
    chk("st1_cnt0", 64'(wb_count), 64'd0);
    chk("st1_idle", 64'(bus_req_valid), 64'd0);
    check_writes("st1_wr");

    // Fill the buffer with ready low, then one pop frees a slot a cycle late.
    bus_req_ready = 1'b0;
    cpu_memwr     = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_addr  = 32'h100 + 32'(i * 4);
      cpu_wdata = $urandom;
      exp_wr.push_back({cpu_addr, cpu_wdata});
      #1;
      chk("fill_stall", 64'(cpu_stall), 64'd0);
      chk("fill_cnt", 64'(wb_count), 64'(i));
      tick();
    end
    cpu_addr  = 32'h200;
    cpu_wdata = $urandom;
    #1;
    chk("full_stall", 64'(cpu_stall), 64'd1);
    chk("full_cnt", 64'(wb_count), 64'(DEPTH));
    bus_req_ready = 1'b1;
    #1;
    chk("full_stall_pop", 64'(cpu_stall), 64'd1);
    tick();
    bus_req_ready = 1'b0;
    #1;
    chk("after_pop_cnt", 64'(wb_count), 64'(DEPTH - 1));
    chk("after_pop_stall", 64'(cpu_stall), 64'd0);
    exp_wr.push_back({cpu_addr, cpu_wdata});
    tick();
    cpu_memwr = 1'b0;
    #1;
    chk("refill_cnt", 64'(wb_count), 64'(DEPTH));
    drain_all();
    check_writes("fill_wr");

    // Minimum-latency load with an empty buffer.
    tick();
    cpu_memrd     = 1'b1;
    cpu_addr      = 32'h20;
    bus_req_ready = 1'b1;
    #1;
    chk("rd_c1_stall", 64'(cpu_stall), 64'd1);
    tick();
    chk("rd_c2_stall", 64'(cpu_stall), 64'd1);
    chk("rd_c2_valid", 64'(bus_req_valid), 64'd1);
    chk("rd_c2_we", 64'(bus_req_we), 64'd0);
    chk("rd_c2_addr", 64'(bus_req_addr), 64'h20);
    tick();
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 32'h12345678;
    #1;
    chk("rd_c3_stall", 64'(cpu_stall), 64'd1);
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    chk("rd_c4_stall", 64'(cpu_stall), 64'd0);
    chk("rd_c4_data", 64'(cpu_rdata), 64'h12345678);
    tick();
    cpu_memrd = 1'b0;
    #1;
    chk("rd_c5_stall", 64'(cpu_stall), 64'd0);
    chk("rd_c5_valid", 64'(bus_req_valid), 64'd0);
    chk("rd_c5_data", 64'(cpu_rdata), 64'h12345678);
    tick();

    // Store then load to the same address: the write must go first.
    do_store(32'h40, $urandom, 0);
    do_load(32'h40, 0);
    check_writes("raw_wr");
    chk("raw_no_wr_in_rd", 64'(wr_during_rd), 64'd0);

    // Reset while waiting for a read response; the late response is ignored.
    cpu_memrd     = 1'b1;
    cpu_addr      = 32'h30;
    bus_req_ready = 1'b1;
    tick();
    chk("rst_rd_req", 64'({bus_req_valid, bus_req_we}), 64'b10);
    tick();
    chk("rst_rd_wait", 64'(cpu_stall), 64'd1);
    reset     = 1'b1;
    cpu_memrd = 1'b0;
    #1;
    chk("rst_rd_stall", 64'(cpu_stall), 64'd0);
    tick();
    reset         = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 32'hBAD0BAD0;
    #1;
    chk("rst_rd_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_rd_stall2", 64'(cpu_stall), 64'd0);
    chk("rst_rd_valid", 64'(bus_req_valid), 64'd0);
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    chk("rst_rd_rdata2", 64'(cpu_rdata), 64'd0);
    chk("rst_rd_stall3", 64'(cpu_stall), 64'd0);
    tick();

    // Simultaneous load and store behaves as a load only.
    cpu_memwr = 1'b1;
    cpu_wdata = 32'hFEEDF00D;
    do_load(32'h80, 0);
    #1;
    chk("combo_cnt", 64'(wb_count), 64'd0);
    check_writes("combo_wr");

    // Pointer wrap: more stores than entries, all drained in order.
    for (int i = 0; i < 9; i++) begin
      d = $urandom;
      do_store(32'h300 + 32'(i * 4), d, 0);
    end
    drain_all();
    check_writes("wrap_wr");

    // Randomized mix with random ready, response delay and stray responses.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) do_load($urandom, 1);
      else                           do_store($urandom, $urandom, 1);
      if ($urandom_range(0, 4) == 0) begin
        bus_req_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain_all();
    check_writes("rand_wr");
    chk("rand_no_wr_in_rd", 64'(wr_during_rd), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bridge.md
CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 The block SHALL have parameter WB_DEPTH, default 4, meaning write-buffer entries (power of 2, >=2).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 The block SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 The block SHALL have port cpu_memrd  in  1  core load request.
REQ-008 The block SHALL have port cpu_memwr  in  1  core store request.
REQ-009 The block SHALL have port cpu_addr  in  ADDR_W  load/store address.
REQ-010 The block SHALL have port cpu_wdata  in  DATA_W  store data.
REQ-011 The block SHALL have port cpu_rdata  out  DATA_W  registered load data.
REQ-012 The block SHALL have port cpu_stall  out  1  combinational, drives core halt.
REQ-013 The block SHALL have ports bus_req_valid out 1, bus_req_ready in 1, bus_req_we out 1, bus_req_addr out ADDR_W, bus_req_wdata out DATA_W: bus request channel.
REQ-014 The block SHALL have ports bus_rsp_valid in 1, bus_rsp_data in DATA_W: read response channel (writes are posted, no response).
REQ-015 The block SHALL have port wb_count  out  $clog2(WB_DEPTH+1)  write-buffer occupancy.

Function
REQ-016 FSM states SHALL be IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE.
REQ-017 Store: in IDLE, cpu_memwr=1 and cpu_memrd=0, wb_count<WB_DEPTH -> enqueue {cpu_addr,cpu_wdata} at clock edge, cpu_stall=0.
REQ-018 Store with wb_count==WB_DEPTH SHALL give cpu_stall=1, no enqueue, even if a pop occurs that cycle; enqueue on first cycle not full.
REQ-019 Load in IDLE: cpu_memrd=1 -> cpu_stall=1; next state DRAIN if wb_count>0, else RD_REQ.
REQ-020 DRAIN: cpu_stall=1; -> RD_REQ on the cycle after wb_count reaches 0.
REQ-021 RD_REQ: bus_req_valid=1, bus_req_we=0, bus_req_addr=cpu_addr; cpu_stall=1; -> RD_WAIT when bus_req_ready=1.
REQ-022 RD_WAIT: cpu_stall=1; on bus_rsp_valid=1 latch bus_rsp_data into cpu_rdata, -> RD_DONE.
REQ-023 RD_DONE: cpu_stall=0 exactly one cycle, cpu_rdata valid; -> IDLE unconditionally (no re-trigger from held cpu_memrd).
REQ-024 Min load latency with empty buffer, ready=1, response next cycle: stall high 3 cycles (IDLE, RD_REQ, RD_WAIT), data usable in cycle 4.
REQ-025 Drain: in IDLE, DRAIN, RD_DONE with wb_count>0, bus_req_valid=1, bus_req_we=1, addr/wdata = buffer head; pop on bus_req_ready=1.
REQ-026 No write SHALL be issued in RD_REQ or RD_WAIT; loads never overtake buffered stores.
REQ-027 bus_req_addr/wdata/we SHALL stay stable while bus_req_valid=1 and bus_req_ready=0.
REQ-028 cpu_memrd=1 and cpu_memwr=1 together SHALL be treated as a load; the store is dropped.
REQ-029 bus_rsp_valid outside RD_WAIT SHALL be ignored.
REQ-030 Buffer pointers SHALL wrap modulo WB_DEPTH; wb_count SHALL count 0..WB_DEPTH; push and pop in the same cycle leave wb_count unchanged.
REQ-031 cpu_rdata SHALL hold its last value except on REQ-022 capture.

Reset
REQ-032 reset=1 SHALL set FSM to IDLE, wb_count=0, pointers=0, cpu_rdata=0, bus_req_valid=0, bus_req_we=0; buffered stores discarded.
REQ-033 reset mid-read SHALL abandon the transaction; a later response is ignored (REQ-029).
REQ-034 During reset cycle cpu_stall SHALL be 0 and no enqueue occurs.

Verification
REQ-035 Store 0xDEADBEEF to 0x10, ready=1 -> no stall; next cycle bus write we=1 addr 0x10 data 0xDEADBEEF; wb_count 1 -> 0.
REQ-036 5 back-to-back stores, ready=0 -> wb_count=4, cpu_stall=1 on 5th; ready=1 one cycle -> 5th enqueued next cycle, count stays 4.
REQ-037 Load 0x20 with buffer empty, ready=1, rsp 0x12345678 one cycle later -> stall 3 cycles, cpu_rdata=0x12345678 in RD_DONE.
REQ-038 Store 0x40 then load 0x40, ready=1 -> write 0x40 on bus before read request; never both in one cycle.
REQ-039 Reset asserted in RD_WAIT, rsp_valid next cycle -> cpu_rdata=0, FSM IDLE, stall 0.
REQ-040 memrd=memwr=1 -> read issued, wb_count unchanged; wrap test: 9 stores with ready=1 -> all 9 drained in order.
